// File: rtl/ycr_reset_seq_ctrl.sv
// Reset sequencer: holds all reset domains, then releases them one at a time in index
// order, waiting for each buffer cell's status acknowledge before the next release.
module ycr_reset_seq_ctrl #(
    parameter  int NUM_DOMAINS    = 3,
    parameter  int HOLD_CYCLES    = 16,
    parameter  int STATUS_TIMEOUT = 255,
    localparam int CNT_MAX        = (HOLD_CYCLES > STATUS_TIMEOUT) ? HOLD_CYCLES : STATUS_TIMEOUT,
    localparam int CW             = $clog2(CNT_MAX + 1),
    localparam int IW             = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n_mux,
    input  logic                   test_mode,
    input  logic                   test_rst_n,
    input  logic                   sw_rst_req,
    input  logic [NUM_DOMAINS-1:0] dom_status_n,
    output logic [NUM_DOMAINS-1:0] dom_rst_n_in,
    output logic                   seq_busy,
    output logic                   seq_done,
    output logic                   seq_err,
    output logic [IW-1:0]          err_dom
);

    typedef enum logic [1:0] {
        S_HOLD     = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_DONE     = 2'd2,
        S_ERR      = 2'd3
    } state_t;

    localparam logic [CW-1:0]          HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]          TOUT_LAST = CW'(STATUS_TIMEOUT - 1);
    localparam logic [IW-1:0]          IDX_LAST  = IW'(NUM_DOMAINS - 1);
    localparam logic [NUM_DOMAINS-1:0] DOM_ONE   = NUM_DOMAINS'(1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CW-1:0]            r_cnt;
    logic [CW-1:0]            w_cnt_nxt;
    logic [IW-1:0]            r_idx;
    logic [IW-1:0]            w_idx_nxt;
    logic [NUM_DOMAINS-1:0]   r_dom_rst_n;
    logic [NUM_DOMAINS-1:0]   w_dom_rst_n_nxt;
    logic                     r_seq_done;
    logic                     w_seq_done_nxt;
    logic                     r_seq_err;
    logic                     w_seq_err_nxt;
    logic [IW-1:0]            r_err_dom;
    logic [IW-1:0]            w_err_dom_nxt;
    logic                     w_ack;
    logic                     w_timeout;

    // Lost-status reporting names the lowest domain whose status dropped.
    function automatic logic [IW-1:0] lowest_zero(input logic [NUM_DOMAINS-1:0] v);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
            if (!v[i]) idx = IW'(i);
        end
        return idx;
    endfunction

    assign w_ack     = dom_status_n[r_idx];
    assign w_timeout = (r_cnt == TOUT_LAST);

    always_ff @(posedge clk or negedge rst_n_mux) begin
        if (!rst_n_mux) begin
            r_state     <= S_HOLD;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_dom_rst_n <= '0;
            r_seq_done  <= 1'b0;
            r_seq_err   <= 1'b0;
            r_err_dom   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_dom_rst_n <= w_dom_rst_n_nxt;
            r_seq_done  <= w_seq_done_nxt;
            r_seq_err   <= w_seq_err_nxt;
            r_err_dom   <= w_err_dom_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_idx_nxt       = r_idx;
        w_dom_rst_n_nxt = r_dom_rst_n;
        w_seq_done_nxt  = r_seq_done;
        w_seq_err_nxt   = r_seq_err;
        w_err_dom_nxt   = r_err_dom;

        // Software re-reset overrides every other transition, including DONE entry.
        if (sw_rst_req) begin
            w_state_nxt     = S_HOLD;
            w_cnt_nxt       = '0;
            w_idx_nxt       = '0;
            w_dom_rst_n_nxt = '0;
            w_seq_done_nxt  = 1'b0;
            w_seq_err_nxt   = 1'b0;
            w_err_dom_nxt   = '0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    w_dom_rst_n_nxt = '0;
                    if (r_cnt == HOLD_LAST) begin
                        w_dom_rst_n_nxt = DOM_ONE;
                        w_idx_nxt       = '0;
                        w_cnt_nxt       = '0;
                        w_state_nxt     = S_WAIT_ACK;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                S_WAIT_ACK: begin
                    // An acknowledge arriving on the timeout cycle still counts.
                    if (w_ack) begin
                        if (r_idx == IDX_LAST) begin
                            w_state_nxt    = S_DONE;
                            w_seq_done_nxt = 1'b1;
                        end else begin
                            w_dom_rst_n_nxt = r_dom_rst_n | (DOM_ONE << (r_idx + IW'(1)));
                            w_idx_nxt       = r_idx + IW'(1);
                            w_cnt_nxt       = '0;
                        end
                    end else if (w_timeout) begin
                        w_state_nxt   = S_ERR;
                        w_seq_err_nxt = 1'b1;
                        w_err_dom_nxt = r_idx;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (!(&dom_status_n)) begin
                        w_state_nxt    = S_ERR;
                        w_seq_err_nxt  = 1'b1;
                        w_seq_done_nxt = 1'b0;
                        w_err_dom_nxt  = lowest_zero(dom_status_n);
                    end
                end
                S_ERR: begin
                end
                default: begin
                    w_state_nxt = S_HOLD;
                end
            endcase
        end
    end

    // Test mode overrides the reset lines directly while the FSM keeps running.
    always_comb begin
        seq_busy     = (r_state == S_HOLD) || (r_state == S_WAIT_ACK);
        dom_rst_n_in = test_mode ? {NUM_DOMAINS{test_rst_n}} : r_dom_rst_n;
    end

    assign seq_done = r_seq_done;
    assign seq_err  = r_seq_err;
    assign err_dom  = r_err_dom;

endmodule

// File: tb/tb_ycr_reset_seq_ctrl.sv
// Directed bench for ycr_reset_seq_ctrl; buffer-cell status is modelled as the
// reset line delayed by one clock, with per-bit tie-off and force overrides.
module tb_ycr_reset_seq_ctrl;
    localparam int N = 3;

    logic         clk        = 1'b0;
    logic         rst_n_mux  = 1'b0;
    logic         test_mode  = 1'b0;
    logic         test_rst_n = 1'b1;
    logic         sw_rst_req = 1'b0;
    logic [N-1:0] dom_status_n;
    logic [N-1:0] dom_rst_n_in;
    logic         seq_busy;
    logic         seq_done;
    logic         seq_err;
    logic [1:0]   err_dom;

    logic [N-1:0] r_stat    = '0;
    logic [N-1:0] tie_mask  = '1;
    logic [N-1:0] force_val = '0;
    logic         force_en  = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    ycr_reset_seq_ctrl #(
        .NUM_DOMAINS   (3),
        .HOLD_CYCLES   (4),
        .STATUS_TIMEOUT(8)
    ) dut (
        .clk          (clk),
        .rst_n_mux    (rst_n_mux),
        .test_mode    (test_mode),
        .test_rst_n   (test_rst_n),
        .sw_rst_req   (sw_rst_req),
        .dom_status_n (dom_status_n),
        .dom_rst_n_in (dom_rst_n_in),
        .seq_busy     (seq_busy),
        .seq_done     (seq_done),
        .seq_err      (seq_err),
        .err_dom      (err_dom)
    );

    always #5 clk = ~clk;
    always @(posedge clk) r_stat <= dom_rst_n_in;
    assign dom_status_n = force_en ? force_val : (r_stat & tie_mask);

    task automatic edge_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        rst_n_mux  = 1'b0;
        sw_rst_req = 1'b0;
        test_mode  = 1'b0;
        test_rst_n = 1'b1;
        tie_mask   = '1;
        force_en   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n_mux = 1'b1;
    endtask

    // Expects to be entered right after the release point (reset or sw_rst_req drop).
    task automatic run_release_seq(input string tag);
        logic [N-1:0] exp_dom;
        logic         exp_done;
        logic         exp_busy;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            exp_dom  = (e >= 8) ? 3'b111 : (e >= 6) ? 3'b011 : (e >= 4) ? 3'b001 : 3'b000;
            exp_done = (e >= 10);
            exp_busy = (e < 10);
            n_checks++;
            if (dom_rst_n_in !== exp_dom) begin
                n_fail++;
                $display("FAIL %s_dom edge%0d: got %b want %b", tag, e, dom_rst_n_in, exp_dom);
            end
            n_checks++;
            if (seq_done !== exp_done) begin
                n_fail++;
                $display("FAIL %s_done edge%0d: got %b want %b", tag, e, seq_done, exp_done);
            end
            n_checks++;
            if (seq_busy !== exp_busy) begin
                n_fail++;
                $display("FAIL %s_busy edge%0d: got %b want %b", tag, e, seq_busy, exp_busy);
            end
        end
    endtask

    task automatic sw_pulse();
        @(negedge clk);
        sw_rst_req = 1'b1;
        edge_n(1);
        n_checks++;
        if (dom_rst_n_in !== 3'b000 || seq_err !== 1'b0 || seq_busy !== 1'b1 || seq_done !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_pulse_clear: got dom=%b err=%b busy=%b done=%b want 000 0 1 0",
                     dom_rst_n_in, seq_err, seq_busy, seq_done);
        end
        @(negedge clk);
        sw_rst_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_mux = 1'b0;
        #2;
        n_checks++;
        if (dom_rst_n_in !== 3'b000 || seq_busy !== 1'b1 || seq_done !== 1'b0 ||
            seq_err !== 1'b0 || err_dom !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got dom=%b busy=%b done=%b err=%b err_dom=%0d want 000 1 0 0 0",
                     dom_rst_n_in, seq_busy, seq_done, seq_err, err_dom);
        end
        edge_n(3);
        n_checks++;
        if (dom_rst_n_in !== 3'b000 || seq_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_held: got dom=%b busy=%b want 000 1", dom_rst_n_in, seq_busy);
        end
    endtask

    task automatic test_sequence();
        hold_reset();
        run_release_seq("seq");
    endtask

    task automatic test_timeout();
        hold_reset();
        tie_mask = 3'b101;
        edge_n(13);
        n_checks++;
        if (seq_err !== 1'b0 || dom_rst_n_in !== 3'b011) begin
            n_fail++;
            $display("FAIL tout_before: got err=%b dom=%b want 0 011", seq_err, dom_rst_n_in);
        end
        edge_n(1);
        n_checks++;
        if (seq_err !== 1'b1 || err_dom !== 2'd1 || dom_rst_n_in !== 3'b011 ||
            seq_done !== 1'b0 || seq_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL tout_err: got err=%b err_dom=%0d dom=%b done=%b busy=%b want 1 1 011 0 0",
                     seq_err, err_dom, dom_rst_n_in, seq_done, seq_busy);
        end
        tie_mask = '1;
        edge_n(4);
        n_checks++;
        if (seq_err !== 1'b1 || dom_rst_n_in !== 3'b011 || seq_done !== 1'b0) begin
            n_fail++;
            $display("FAIL tout_frozen: got err=%b dom=%b done=%b want 1 011 0",
                     seq_err, dom_rst_n_in, seq_done);
        end
        sw_pulse();
        run_release_seq("replay");
    endtask

    task automatic test_lost_status(input logic [N-1:0] fv, input logic [1:0] exp_idx);
        @(negedge clk);
        force_val = fv;
        force_en  = 1'b1;
        edge_n(1);
        n_checks++;
        if (seq_err !== 1'b1 || err_dom !== exp_idx || seq_done !== 1'b0 ||
            dom_rst_n_in !== 3'b111) begin
            n_fail++;
            $display("FAIL lost_%b: got err=%b err_dom=%0d done=%b dom=%b want 1 %0d 0 111",
                     fv, seq_err, err_dom, seq_done, dom_rst_n_in, exp_idx);
        end
        @(negedge clk);
        force_en = 1'b0;
    endtask

    task automatic test_sw_hold();
        hold_reset();
        edge_n(6);
        n_checks++;
        if (dom_rst_n_in !== 3'b011) begin
            n_fail++;
            $display("FAIL swh_pre: got %b want 011", dom_rst_n_in);
        end
        tie_mask = 3'b101;
        @(negedge clk);
        sw_rst_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            edge_n(1);
            n_checks++;
            if (dom_rst_n_in !== 3'b000 || seq_busy !== 1'b1 || seq_err !== 1'b0) begin
                n_fail++;
                $display("FAIL swh_held cyc%0d: got dom=%b busy=%b err=%b want 000 1 0",
                         c, dom_rst_n_in, seq_busy, seq_err);
            end
        end
        @(negedge clk);
        sw_rst_req = 1'b0;
        tie_mask   = '1;
        run_release_seq("swh");
    endtask

    task automatic test_test_mode();
        int k;
        rst_n_mux  = 1'b0;
        test_mode  = 1'b1;
        test_rst_n = 1'b0;
        #1;
        n_checks++;
        if (dom_rst_n_in !== 3'b000) begin
            n_fail++;
            $display("FAIL tm_low: got %b want 000", dom_rst_n_in);
        end
        test_rst_n = 1'b1;
        #1;
        n_checks++;
        if (dom_rst_n_in !== 3'b111) begin
            n_fail++;
            $display("FAIL tm_high: got %b want 111", dom_rst_n_in);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n_mux = 1'b1;
        k = 0;
        while (seq_done !== 1'b1 && k < 40) begin
            edge_n(1);
            k++;
        end
        n_checks++;
        if (seq_done !== 1'b1) begin
            n_fail++;
            $display("FAIL tm_done: got seq_done=%b after %0d edges want 1", seq_done, k);
        end
        @(negedge clk);
        test_rst_n = 1'b0;
        #1;
        n_checks++;
        if (dom_rst_n_in !== 3'b000) begin
            n_fail++;
            $display("FAIL tm_toggle_low: got %b want 000", dom_rst_n_in);
        end
        test_rst_n = 1'b1;
        test_mode  = 1'b0;
        #1;
        n_checks++;
        if (dom_rst_n_in !== 3'b111 || seq_done !== 1'b1) begin
            n_fail++;
            $display("FAIL tm_exit: got dom=%b done=%b want 111 1", dom_rst_n_in, seq_done);
        end
    endtask

    task automatic test_async_reset();
        hold_reset();
        edge_n(6);
        #2;
        rst_n_mux = 1'b0;
        #1;
        n_checks++;
        if (dom_rst_n_in !== 3'b000 || seq_busy !== 1'b1 || seq_err !== 1'b0 || seq_done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_wait: got dom=%b busy=%b err=%b done=%b want 000 1 0 0",
                     dom_rst_n_in, seq_busy, seq_err, seq_done);
        end
        hold_reset();
        tie_mask = 3'b101;
        edge_n(14);
        #2;
        rst_n_mux = 1'b0;
        #1;
        n_checks++;
        if (dom_rst_n_in !== 3'b000 || seq_busy !== 1'b1 || seq_err !== 1'b0 || err_dom !== 2'd0) begin
            n_fail++;
            $display("FAIL async_err: got dom=%b busy=%b err=%b err_dom=%0d want 000 1 0 0",
                     dom_rst_n_in, seq_busy, seq_err, err_dom);
        end
        tie_mask = '1;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_timeout();
        test_lost_status(3'b101, 2'd1);
        sw_pulse();
        run_release_seq("replay2");
        test_lost_status(3'b001, 2'd1);
        test_sw_hold();
        test_test_mode();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
